// File: rtl/core_seq_pkg.sv
// Shared types and constants for the tile sequencer: FSM states, the bit positions
// of the 45-bit core instruction bus, and its idle (reset) value.
package core_seq_pkg;

  localparam int ADDR_W = 11;
  localparam int CNT_W  = 11;
  localparam int INST_W = 45;

  typedef enum logic [2:0] {
    IDLE,
    W_RD,
    W_LD,
    X_RD,
    DRAIN,
    DONE
  } state_t;

  localparam int INST_LOAD     = 0;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_L0_WR    = 2;
  localparam int INST_L0_RD    = 3;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_A_XMEM   = 7;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_CEN_XMEM = 19;
  localparam int INST_WA_PMEM  = 20;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_ACC      = 33;
  localparam int INST_RA_PMEM  = 34;

  // Both memories disabled, xmem write-enable held inactive, all strobes low.
  localparam logic [INST_W-1:0] INST_RESET =
    {11'd0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

endpackage

// File: rtl/seq_addr_gen.sv
// Base-plus-offset address generator: each step issues base + count as a registered
// access strobe, with a copy of the strobe delayed by one cycle for the read data.
module seq_addr_gen
  import core_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] addr,
  output logic              vld,
  output logic              vld_d
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      addr  <= '0;
      vld   <= 1'b0;
      vld_d <= 1'b0;
    end else begin
      vld   <= step;
      vld_d <= vld;
      if (clr) begin
        cnt <= '0;
      end else if (step) begin
        // Wraps silently modulo 2^ADDR_W.
        addr <= base + ADDR_W'(cnt);
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_seq.sv
// Weight-stationary tile sequencer: loads weights through L0 into the PE array,
// streams activations, then drains OFIFO rows into psum SRAM and pulses done.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int DRAIN_TO = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [CNT_W-1:0]  num_x,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              xw_mode,
  output logic [1:0]        pmem_mode,
  output logic              execution_mode,
  output logic              ififo_mode,
  output logic              relu_en,
  output logic              sfp_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TO_W = $clog2(DRAIN_TO + 1);
  localparam logic [CNT_W-1:0] ROW_C   = CNT_W'(ROW);
  localparam logic [CNT_W-1:0] LD_LEN  = CNT_W'(ROW + COL);
  localparam logic [CNT_W-1:0] LD_END  = CNT_W'(ROW + COL - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(DRAIN_TO - 1);

  state_t            state;
  logic [ADDR_W-1:0] w_base_reg, x_base_reg, p_base_reg;
  logic [CNT_W-1:0]  num_x_reg;
  logic [CNT_W-1:0]  phase_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [TO_W-1:0]   idle_cnt;
  logic              load_reg, l0_rd_reg, execute_reg, ofifo_rd_reg;
  logic              xw_mode_reg, sfp_reset_reg, busy_reg, done_reg, err_reg;

  logic [CNT_W-1:0]  x_cnt, p_cnt;
  logic [ADDR_W-1:0] x_addr, p_addr, x_base_sel;
  logic              x_vld, x_vld_d, p_vld, p_vld_d;
  logic              accept, x_step, x_clr, take;

  assign accept     = (state == IDLE) && start && (num_x != '0);
  assign x_step     = ((state == W_RD) && (x_cnt < ROW_C)) ||
                      ((state == X_RD) && (x_cnt < num_x_reg));
  assign x_clr      = accept || ((state == W_LD) && (phase_cnt == LD_LEN));
  assign x_base_sel = (state == W_RD) ? w_base_reg : x_base_reg;
  assign take       = (state == DRAIN) && ofifo_valid && (rd_cnt < num_x_reg);

  seq_addr_gen u_xmem_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (x_clr),
    .step  (x_step),
    .base  (x_base_sel),
    .cnt   (x_cnt),
    .addr  (x_addr),
    .vld   (x_vld),
    .vld_d (x_vld_d)
  );

  // The psum write trails the OFIFO read by one cycle.
  seq_addr_gen u_pmem_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .step  (ofifo_rd_reg),
    .base  (p_base_reg),
    .cnt   (p_cnt),
    .addr  (p_addr),
    .vld   (p_vld),
    .vld_d (p_vld_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      w_base_reg    <= '0;
      x_base_reg    <= '0;
      p_base_reg    <= '0;
      num_x_reg     <= '0;
      phase_cnt     <= '0;
      rd_cnt        <= '0;
      idle_cnt      <= '0;
      load_reg      <= 1'b0;
      l0_rd_reg     <= 1'b0;
      execute_reg   <= 1'b0;
      ofifo_rd_reg  <= 1'b0;
      xw_mode_reg   <= 1'b0;
      sfp_reset_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      ofifo_rd_reg <= take;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_x == '0) begin
              err_reg <= 1'b1;
            end else begin
              w_base_reg    <= w_base;
              x_base_reg    <= x_base;
              p_base_reg    <= p_base;
              num_x_reg     <= num_x;
              phase_cnt     <= '0;
              rd_cnt        <= '0;
              idle_cnt      <= '0;
              xw_mode_reg   <= 1'b1;
              sfp_reset_reg <= 1'b0;
              busy_reg      <= 1'b1;
              state         <= W_RD;
            end
          end
        end
        W_RD: begin
          // Leave once the last weight word has been written into L0.
          if ((x_cnt == ROW_C) && !x_vld && x_vld_d) begin
            load_reg  <= 1'b1;
            l0_rd_reg <= 1'b1;
            phase_cnt <= '0;
            state     <= W_LD;
          end
        end
        W_LD: begin
          phase_cnt <= phase_cnt + 1'b1;
          if (phase_cnt == LD_END) begin
            load_reg  <= 1'b0;
            l0_rd_reg <= 1'b0;
          end
          if (phase_cnt == LD_LEN) begin
            xw_mode_reg <= 1'b0;
            phase_cnt   <= '0;
            state       <= X_RD;
          end
        end
        X_RD: begin
          // Execute tracks the L0 writes, then runs ROW more cycles to flush the array.
          if (x_vld) begin
            execute_reg <= 1'b1;
            l0_rd_reg   <= 1'b1;
            phase_cnt   <= '0;
          end else if (execute_reg) begin
            if (phase_cnt == ROW_C) begin
              execute_reg <= 1'b0;
              l0_rd_reg   <= 1'b0;
              idle_cnt    <= '0;
              state       <= DRAIN;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (take) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
          if (p_vld_d && (p_cnt == num_x_reg)) begin
            done_reg <= 1'b1;
            state    <= DONE;
          end else if (ofifo_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TO_LAST) begin
            err_reg       <= 1'b1;
            busy_reg      <= 1'b0;
            sfp_reset_reg <= 1'b1;
            state         <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE: begin
          busy_reg      <= 1'b0;
          sfp_reset_reg <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    inst                            = INST_RESET;
    inst[INST_CEN_PMEM]             = ~p_vld;
    inst[INST_WEN_PMEM]             = ~p_vld;
    inst[INST_WA_PMEM +: ADDR_W]    = p_addr;
    inst[INST_CEN_XMEM]             = ~x_vld;
    inst[INST_A_XMEM +: ADDR_W]     = x_addr;
    inst[INST_OFIFO_RD]             = ofifo_rd_reg;
    inst[INST_L0_RD]                = l0_rd_reg;
    inst[INST_L0_WR]                = x_vld_d;
    inst[INST_EXECUTE]              = execute_reg;
    inst[INST_LOAD]                 = load_reg;
  end

  assign xw_mode        = xw_mode_reg;
  assign pmem_mode      = 2'b00;
  assign execution_mode = 1'b0;
  assign ififo_mode     = 1'b0;
  assign relu_en        = 1'b0;
  assign sfp_reset      = sfp_reset_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: runs whole tile passes and checks the instruction
// stream (xmem reads, L0 writes, load length, psum writes) against hand-computed values.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, p_base = '0, num_x = '0;
  logic [44:0] inst;
  logic        xw_mode;
  logic [1:0]  pmem_mode;
  logic        execution_mode, ififo_mode, relu_en, sfp_reset, busy, done, err;

  localparam logic [44:0] RST_INST =
    {11'd0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  core_seq dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .w_base         (w_base),
    .x_base         (x_base),
    .p_base         (p_base),
    .num_x          (num_x),
    .ofifo_valid    (ofifo_valid),
    .inst           (inst),
    .xw_mode        (xw_mode),
    .pmem_mode      (pmem_mode),
    .execution_mode (execution_mode),
    .ififo_mode     (ififo_mode),
    .relu_en        (relu_en),
    .sfp_reset      (sfp_reset),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observation log, filled on falling edges.
  logic [10:0] xrd_q[$];
  logic [10:0] pw_q[$];
  int load_cnt = 0, l0wr_cnt = 0, l0_viol = 0, wen_viol = 0, done_cnt = 0, ofrd_cnt = 0;
  bit prev_rd = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_rd = 1'b0;
    end else begin
      if (inst[2] !== prev_rd) l0_viol++;
      prev_rd = !inst[19];
      if (!inst[19]) xrd_q.push_back(inst[17:7]);
      if (inst[2]) l0wr_cnt++;
      if (inst[0]) load_cnt++;
      if (!inst[32]) begin
        pw_q.push_back(inst[30:20]);
        if (inst[31]) wen_viol++;
      end
      if (done) done_cnt++;
      if (inst[6]) ofrd_cnt++;
    end
  end

  int xb, pb, lb, wb, db, ob, vb, lvb;
  int cyc;
  bit fin;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mark();
    xb = xrd_q.size(); pb = pw_q.size(); lb = load_cnt; wb = l0wr_cnt;
    db = done_cnt; ob = ofrd_cnt; vb = wen_viol; lvb = l0_viol;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic kick(input int w, input int x, input int p, input int n);
    w_base = 11'(w); x_base = 11'(x); p_base = 11'(p); num_x = 11'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // pat: 0 = valid held 1, 1 = valid pattern 1,0,0,..., 2 = valid held 0.
  task automatic wait_end(input int budget, input int pat, input int restart);
    fin = 1'b0; cyc = 0;
    while (cyc < budget && !fin) begin
      ofifo_valid = (pat == 0) ? 1'b1 : (pat == 1) ? ((cyc % 3) == 0) : 1'b0;
      start = (cyc == restart);
      @(posedge clk); #1;
      cyc++;
      if (done_cnt > db || err) fin = 1'b1;
    end
    start = 1'b0; ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify_pass(input string tag, input int w, input int x, input int p, input int n);
    logic [10:0] e;
    chk({tag, "_finished"}, 64'(fin), 1);
    chk({tag, "_nread"}, 64'(xrd_q.size() - xb), 64'(8 + n));
    for (int i = 0; i < 8 + n; i++) begin
      e = (i < 8) ? 11'(w + i) : 11'(x + i - 8);
      if (xb + i < xrd_q.size()) chk({tag, "_a_xmem"}, 64'(xrd_q[xb + i]), 64'(e));
    end
    chk({tag, "_l0wr_cnt"}, 64'(l0wr_cnt - wb), 64'(8 + n));
    chk({tag, "_l0wr_lag"}, 64'(l0_viol - lvb), 0);
    chk({tag, "_load_cycles"}, 64'(load_cnt - lb), 16);
    chk({tag, "_nwrite"}, 64'(pw_q.size() - pb), 64'(n));
    for (int i = 0; i < n; i++) begin
      e = 11'(p + i);
      if (pb + i < pw_q.size()) chk({tag, "_wa_pmem"}, 64'(pw_q[pb + i]), 64'(e));
    end
    chk({tag, "_wen_pmem"}, 64'(wen_viol - vb), 0);
    chk({tag, "_ofifo_rd"}, 64'(ofrd_cnt - ob), 64'(n));
    chk({tag, "_done_pulses"}, 64'(done_cnt - db), 1);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_busy_after"}, 64'(busy), 0);
    chk({tag, "_sfp_after"}, 64'(sfp_reset), 1);
  endtask

  initial begin
    // Reset state, held in reset
    @(posedge clk); #1;
    chk("rst_inst", 64'(inst), 64'(RST_INST));
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_xw_mode", 64'(xw_mode), 0);
    chk("rst_sfp_reset", 64'(sfp_reset), 1);
    chk("fixed_modes", 64'({pmem_mode, execution_mode, ififo_mode, relu_en}), 0);

    // Nominal pass
    do_reset();
    mark();
    kick(0, 16, 100, 4);
    chk("run_busy", 64'(busy), 1);
    chk("run_xw_mode", 64'(xw_mode), 1);
    chk("run_sfp_reset", 64'(sfp_reset), 0);
    wait_end(3000, 0, -1);
    verify_pass("main", 0, 16, 100, 4);
    chk("main_xw_mode_after", 64'(xw_mode), 0);

    // Second start during X_RD is ignored
    do_reset();
    mark();
    kick(0, 16, 100, 4);
    wait_end(3000, 0, 29);
    verify_pass("restart", 0, 16, 100, 4);

    // psum address wrap
    do_reset();
    mark();
    kick(5, 40, 2046, 4);
    wait_end(3000, 0, -1);
    verify_pass("wrap", 5, 40, 2046, 4);

    // Sparse ofifo_valid in DRAIN
    do_reset();
    mark();
    kick(0, 100, 500, 5);
    wait_end(3000, 1, -1);
    verify_pass("toggle", 0, 100, 500, 5);

    // Illegal start with num_x = 0
    do_reset();
    mark();
    kick(0, 16, 100, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("nx0_err", 64'(err), 1);
    chk("nx0_busy", 64'(busy), 0);
    chk("nx0_reads", 64'(xrd_q.size() - xb), 0);
    chk("nx0_done", 64'(done_cnt - db), 0);

    // Drain timeout
    do_reset();
    mark();
    kick(0, 16, 100, 2);
    wait_end(2000, 2, -1);
    chk("to_finished", 64'(fin), 1);
    chk("to_err", 64'(err), 1);
    chk("to_busy", 64'(busy), 0);
    chk("to_done", 64'(done_cnt - db), 0);
    chk("to_writes", 64'(pw_q.size() - pb), 0);
    chk("to_latency_window", 64'(cyc >= 1040 && cyc <= 1090), 1);

    // Reset asserted mid-X_RD
    do_reset();
    mark();
    kick(0, 16, 100, 4);
    for (int i = 0; i < 80 && (xrd_q.size() - xb) <= 8; i++) begin
      ofifo_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_reached_x_rd", 64'((xrd_q.size() - xb) > 8), 1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 64'(busy), 0);
    chk("mid_inst", 64'(inst), 64'(RST_INST));
    chk("mid_sfp_reset", 64'(sfp_reset), 1);
    mark();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ofifo_valid = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_no_pmem_write", 64'(pw_q.size() - pb), 0);
    chk("mid_no_ofifo_rd", 64'(ofrd_cnt - ob), 0);
    chk("mid_busy_after", 64'(busy), 0);
    chk("mid_no_done", 64'(done_cnt - db), 0);
    ofifo_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Tile sequencer sitting directly upstream of the core. It drives the 45-bit instruction bus and the mode pins for one weight-stationary tile pass.
- The pass has three phases:
  - load `row` weight words from weight SRAM into L0, then into the PE array;
  - stream `num_x` activation words through L0 into the array;
  - drain `num_x` OFIFO outputs into psum SRAM.
- Pulses `done` when the last psum write has issued.

Parameters:
- row, 8, PE array rows / L0 lanes
- col, 8, PE array columns
- ADDR_W, 11, SRAM address width (all three memories)
- CNT_W, 11, width of the num_x counter
- DRAIN_TO, 1023, idle cycles tolerated in DRAIN before error

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (clear when 0)
- start  in  1  one-cycle pulse; accepted only in IDLE
- w_base  in  ADDR_W  first weight-SRAM address
- x_base  in  ADDR_W  first activation-SRAM address
- p_base  in  ADDR_W  first psum-SRAM write address
- num_x  in  CNT_W  activation vectors to stream (0 = illegal)
- ofifo_valid  in  1  OFIFO has a full row available
- inst  out  45  core instruction bus
- xw_mode  out  1  1 = weight SRAM drives L0, 0 = activation SRAM
- pmem_mode  out  2  fixed 2'b00 (psum written from OFIFO)
- execution_mode  out  1  fixed 0 (weight-stationary)
- ififo_mode  out  1  fixed 0
- relu_en  out  1  fixed 0
- sfp_reset  out  1  high in IDLE, low otherwise
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky: illegal start or drain timeout

Behaviour:
- inst fields:
  - [44:34] psum RA, held 0
  - [33] acc, 0
  - [32] CEN_pmem, active-low
  - [31] WEN_pmem, active-low
  - [30:20] WA_pmem
  - [19] CEN_xmem, active-low
  - [18] WEN_xmem, held 1 (read only)
  - [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- Reset (async assert, sync release) values:
  - state IDLE; all counters 0;
  - inst = {11'd0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};
  - xw_mode 0, sfp_reset 1, busy 0, done 0, err 0.
- All outputs are registered; the SRAM read latency is 1 cycle.
- IDLE:
  - start with num_x != 0: latch all bases and num_x, set xw_mode=1, go to W_RD.
  - start with num_x == 0: set err, stay in IDLE.
- W_RD, k = 0..row-1:
  - CEN_xmem=0, A_xmem = w_base + k.
  - l0_wr=1 one cycle after each read (delayed valid).
  - After k = row-1 and its trailing l0_wr, go to W_LD.
- W_LD:
  - l0_rd=1 and load=1 for row+col cycles (the kernel-load shift), then 1 idle cycle; xw_mode <= 0; go to X_RD.
- X_RD, j = 0..num_x-1:
  - CEN_xmem=0, A_xmem = x_base + j; l0_wr delayed by 1 as in W_RD.
  - l0_rd=1 and execute=1 from the first l0_wr until the last l0_wr + row cycles (pipeline flush).
  - Then go to DRAIN.
- DRAIN:
  - When ofifo_valid=1: ofifo_rd=1 that cycle. On the next cycle CEN_pmem=0, WEN_pmem=0, WA_pmem = p_base + m, then m++.
  - If ofifo_valid is 0 for DRAIN_TO consecutive cycles: set err, go to IDLE without done.
  - After the write with m = num_x-1: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W; base + offset wraps silently.
- start while busy is ignored (no err).
- reset=0 mid-pass: immediate return to IDLE reset values. No partial write may be issued after the reset edge.
- ofifo_valid outside DRAIN is ignored; ofifo_rd is never asserted outside DRAIN.

Decomposition:
- Package core_seq_pkg holds:
  - state enum (IDLE, W_RD, W_LD, X_RD, DRAIN, DONE);
  - inst bit-index localparams (INST_CEN_PMEM = 32, etc.);
  - the inst reset constant.
- Sub-module seq_addr_gen (base + counter, with 1-cycle delayed read-valid) is instantiated twice: once for xmem, once for pmem.

Test Plan:
- Reset mid-X_RD (assert reset low): next edge busy=0, inst equals the reset constant, and no pmem write follows, even with ofifo_valid=1.
- start with w_base=0, x_base=16, p_base=100, num_x=4, ofifo_valid tied 1:
  - A_xmem runs 0..7, then 16..19; l0_wr trails each read by 1 cycle;
  - load is high for exactly 16 cycles;
  - WA_pmem runs 100..103 with WEN_pmem=0; done pulses once; err=0.
- start with num_x=0 -> err=1, busy stays 0, no CEN_xmem=0 ever.
- p_base=2046, num_x=4 -> WA_pmem runs 2046, 2047, 0, 1.
- DRAIN with ofifo_valid toggling 1,0,0,1,… -> exactly one pmem write per valid, addresses contiguous. Holding ofifo_valid=0 for 1023 cycles -> err=1, return to IDLE, no done.
- start pulsed again during X_RD -> ignored; the pass completes identically to the single-start run.
